// File: rtl/seq_matcher.sv
// seq_matcher: run-time programmable masked input-sequence detector.
// Define SEQ_MATCHER_TIMEOUT_EN to bound how long a hold step may wait on a miss.
module seq_matcher #(
  parameter int IN_W   = 4,
  parameter int DEPTH  = 12,
  parameter int STEP_W = $clog2(DEPTH),
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [IN_W-1:0]   din,
  input  logic              cfg_we,
  input  logic [STEP_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_mask,
  input  logic [IN_W-1:0]   cfg_value,
  input  logic              cfg_hold,
  input  logic              cfg_len_we,
  input  logic [STEP_W:0]   cfg_len,
  input  logic              clear,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              restart
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [STEP_W:0] DEPTH_L = DEPTH[STEP_W:0];
  localparam logic [STEP_W:0] ONE_L   = {{STEP_W{1'b0}}, 1'b1};
  state_t            r_state, w_state_nx;
  logic [STEP_W-1:0] r_step, w_step_nx;
  logic              r_match, w_match_nx, r_restart, w_restart_nx;
  logic [IN_W-1:0]   r_mask [DEPTH];
  logic [IN_W-1:0]   r_value [DEPTH];
  logic              r_hold [DEPTH];
  logic [STEP_W:0]   r_len, w_len_in;
  logic              w_hit, w_last;
`ifdef SEQ_MATCHER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] r_tmo, w_tmo_nx;
`endif
  assign w_hit    = ((din ^ r_value[r_step]) & r_mask[r_step]) == '0;
  assign w_last   = {1'b0, r_step} == r_len - ONE_L;
  assign w_len_in = (cfg_len == '0) ? ONE_L : (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  // Table and length are writable only while the detector is parked in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mask[i]  <= '0;
        r_value[i] <= '0;
        r_hold[i]  <= 1'b0;
      end
      r_len <= ONE_L;
    end else if (r_state == IDLE) begin
      if (cfg_we && ({1'b0, cfg_addr} < DEPTH_L)) begin
        r_mask[cfg_addr]  <= cfg_mask;
        r_value[cfg_addr] <= cfg_value;
        r_hold[cfg_addr]  <= cfg_hold;
      end
      if (cfg_len_we) r_len <= w_len_in;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_match   <= 1'b0;
      r_restart <= 1'b0;
`ifdef SEQ_MATCHER_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_step    <= w_step_nx;
      r_match   <= w_match_nx;
      r_restart <= w_restart_nx;
`ifdef SEQ_MATCHER_TIMEOUT_EN
      r_tmo     <= w_tmo_nx;
`endif
    end
  end
  // Step defaults to 0 so it reads 0 outside RUN and after any fall-back
  always_comb begin
    w_state_nx   = r_state;
    w_step_nx    = '0;
    w_match_nx   = 1'b0;
    w_restart_nx = 1'b0;
`ifdef SEQ_MATCHER_TIMEOUT_EN
    w_tmo_nx     = '0;
`endif
    if (!enable) w_state_nx = IDLE;
    else if (r_state == IDLE) w_state_nx = RUN;
    else if (r_state == DONE) w_state_nx = clear ? RUN : DONE;
    else if (clear) w_state_nx = RUN;
    else if (w_hit) begin
      w_state_nx = w_last ? DONE : RUN;
      w_step_nx  = w_last ? '0 : r_step + 1'b1;
      w_match_nx = w_last;
    end else if (r_hold[r_step]) begin
`ifdef SEQ_MATCHER_TIMEOUT_EN
      w_step_nx    = (r_tmo == TMO_LIM) ? '0 : r_step;
      w_restart_nx = (r_tmo == TMO_LIM) && (r_step != '0);
      w_tmo_nx     = (r_tmo == TMO_LIM) ? '0 : r_tmo + 1'b1;
`else
      w_step_nx = r_step;
`endif
    end else w_restart_nx = r_step != '0;
  end
  assign step    = r_step;
  assign busy    = r_state == RUN;
  assign done    = r_state == DONE;
  assign match   = r_match;
  assign restart = r_restart;
endmodule

// File: tb/tb_seq_matcher.sv
// tb_seq_matcher: scenario tasks push expected {step,busy,done,match,restart} to a scoreboard and compare after each edge.
module tb_seq_matcher;
`ifdef SEQ_MATCHER_TIMEOUT_EN
  localparam int TMO_W = 3;
`else
  localparam int TMO_W = 8;
`endif
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [3:0] din = '0, cfg_addr = '0, cfg_mask = '0, cfg_value = '0, step;
  logic       cfg_we = 1'b0, cfg_hold = 1'b0, cfg_len_we = 1'b0;
  logic [4:0] cfg_len = '0;
  logic       busy, done, match, restart;
  logic [7:0] w_obs;
  logic [7:0] sb[$];
  int         n_run = 0, n_fail = 0;

  typedef struct packed {
    logic       rst, en, clr;
    logic [3:0] d;
    logic [7:0] exp;
  } stim_t;

  seq_matcher #(.IN_W(4), .DEPTH(12), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .din(din),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_hold(cfg_hold), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .clear(clear),
    .step(step), .busy(busy), .done(done), .match(match), .restart(restart)
  );

  always #5 clk = ~clk;
  assign w_obs = {step, busy, done, match, restart};

  function automatic stim_t st(input logic rst, en, clr, input logic [3:0] d,
                               input logic [3:0] s, input logic b, dn, m, r);
    stim_t x;
    x = {rst, en, clr, d, s, b, dn, m, r};
    return x;
  endfunction

  task automatic apply(input stim_t x);
    reset = x.rst; enable = x.en; clear = x.clr; din = x.d;
    sb.push_back(x.exp);
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic we, input logic [3:0] a, m, v, input logic h,
                     input logic lwe, input logic [4:0] l);
    reset = 1'b0; enable = 1'b0; clear = 1'b0;
    cfg_we = we; cfg_addr = a; cfg_mask = m; cfg_value = v; cfg_hold = h;
    cfg_len_we = lwe; cfg_len = l;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_len_we = 1'b0;
  endtask

  task automatic test_reset;
    stim_t s[$];
    logic [7:0] e;
    s.push_back(st(1, 1, 1, 4'hf, 0, 0, 0, 0, 0));
    s.push_back(st(1, 1, 1, 4'hf, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_len_clamp;
    stim_t s[$];
    logic [7:0] e;
    cfg(0, 0, 0, 0, 0, 1, 5'd20);
    s.push_back(st(0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k < 12; k++) s.push_back(st(0, 1, 0, 4'(k), 4'(k), 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL len_clamp[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_match;
    stim_t s[$];
    logic [7:0] e;
    cfg(1, 0, 4'b0100, 4'b0100, 0, 0, 0);
    cfg(1, 1, 4'b1001, 4'b1001, 0, 0, 0);
    cfg(1, 2, 4'b0100, 4'b0000, 0, 1, 5'd3);
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h9, 2, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 0, 1, 1, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 0, 1, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 0, 0, 1, 0, 0));
    s.push_back(st(0, 1, 1, 4'h0, 0, 1, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL match[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_restart;
    stim_t s[$];
    logic [7:0] e;
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 1));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 1, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h9, 2, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL restart[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_hold;
    stim_t s[$];
    logic [7:0] e;
    cfg(1, 1, 4'b0001, 4'b0001, 1, 0, 0);
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
`ifdef SEQ_MATCHER_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) s.push_back(st(0, 1, 0, 4'h0, 1, 1, 0, 0, 0));
      s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 1));
      s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    end
`else
    for (int k = 0; k < 10; k++) s.push_back(st(0, 1, 0, 4'h0, 1, 1, 0, 0, 0));
`endif
    s.push_back(st(0, 1, 0, 4'h1, 2, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL hold[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_cfg_write;
    stim_t s[$];
    logic [7:0] e;
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      if (i == 1) begin
        cfg_we = 1'b1; cfg_addr = 0; cfg_mask = 0; cfg_value = 0; cfg_len_we = 1'b1; cfg_len = 5'd1;
      end
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL cfg_in_run[%0d]: got %h want %h", i, w_obs, e); end
    end
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    cfg(0, 0, 0, 0, 0, 1, 5'd0);
    cfg(1, 4'd12, 0, 0, 0, 0, 0);
    s.delete();
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 0, 0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL cfg_len0[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_enable_drop;
    stim_t s[$];
    logic [7:0] e;
    cfg(0, 0, 0, 0, 0, 1, 5'd3);
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h1, 2, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL enable_drop[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  task automatic test_reset_mid;
    stim_t s[$];
    logic [7:0] e;
    s.push_back(st(0, 1, 0, 4'h0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h4, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'h1, 2, 1, 0, 0, 0));
    s.push_back(st(1, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'hf, 0, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 4'hf, 0, 0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front(); n_run++;
      if (w_obs !== e) begin n_fail++; $display("FAIL reset_mid[%0d]: got %h want %h", i, w_obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_len_clamp();
    test_match();
    test_restart();
    test_hold();
    test_cfg_write();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
